apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_slv_decode.sv | 30 +++
 rtl/apb_master_bridge.sv | 194 +++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: initiator FSM encoding, the read-strobe value and the
// response error codes that other APB initiators/slaves reuse.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // APB4 reads carry no byte strobes; replicate this bit to the strobe width.
    localparam logic STRB_READ = 1'b0;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        SLV_ERR     = 2'd1,
        DEC_ERR     = 2'd2,
        TIMEOUT_ERR = 2'd3
    } apb_err_e;

endpackage

// File: rtl/apb_slv_decode.sv
// Combinational slave decoder: address -> one-hot PSEL vector, plus a flag when
// the slave-index field points past the last populated slave.
module apb_slv_decode #(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int SEL_W   = 4
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               decode_err_o
);

    logic [SEL_W-1:0] idx;
    logic             unused_addr;

    assign idx = addr_i[SEL_LSB +: SEL_W];
    // Only the index field matters here; the rest of the address is folded away.
    assign unused_addr = ^addr_i;

    always_comb begin
        sel_o = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            sel_o[k] = (idx == SEL_W'(k));
        end
    end

    assign decode_err_o = ~|sel_o;

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 initiator: accepts one core request at a time, decodes the target slave,
// runs SETUP/ACCESS with a bounded wait and returns a registered response.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = DATA_W / 8,
    parameter int NUM_SLV     = 4,
    parameter int SEL_LSB     = 12,
    parameter int SEL_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_write,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [STRB_W-1:0]         req_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [STRB_W-1:0]         PSTRB,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    apb_state_e          state_q, state_d;
    logic                ready_q;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    apb_err_e            err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_err;
    logic                accept;
    logic                slv_ready;
    logic                slv_err;
    logic                expired;
    logic [DATA_W-1:0]   slv_rdata;

    apb_slv_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SEL_LSB (SEL_LSB),
        .SEL_W   (SEL_W)
    ) u_decode (
        .addr_i       (req_addr),
        .sel_o        (dec_sel),
        .decode_err_o (dec_err)
    );

    assign accept    = req_valid & ready_q;
    // The latched one-hot select masks away every non-selected slave.
    assign slv_ready = |(PREADY & psel_q);
    assign slv_err   = |(PSLVERR & psel_q);
    assign expired   = (cnt_q == CNT_LAST);

    always_comb begin
        slv_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            slv_rdata = slv_rdata | (PRDATA[k*DATA_W +: DATA_W] & {DATA_W{psel_q[k]}});
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = dec_err ? ST_RESP : ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (slv_ready || expired) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every always_comb output starts from a hold default so no path infers a latch.
    always_comb begin
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        valid_d   = valid_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    pstrb_d  = req_write ? req_strb : {STRB_W{STRB_READ}};
                    cnt_d    = '0;
                    if (dec_err) begin
                        valid_d = 1'b1;
                        rdata_d = '0;
                        err_d   = DEC_ERR;
                    end else begin
                        psel_d  = dec_sel;
                    end
                end
            end
            ST_SETUP: penable_d = 1'b1;
            ST_ACCESS: begin
                if (slv_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    valid_d   = 1'b1;
                    rdata_d   = pwrite_q ? '0 : slv_rdata;
                    err_d     = slv_err ? SLV_ERR : ERR_NONE;
                end else if (expired) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    valid_d   = 1'b1;
                    rdata_d   = '0;
                    err_d     = TIMEOUT_ERR;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: if (rsp_ready) valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ready_q   <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            valid_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= ERR_NONE;
            cnt_q     <= '0;
        end else begin
            ready_q   <= (state_d == ST_IDLE);
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_ready = ready_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = (err_q != ERR_NONE);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized
// transfers against a transfer-level reference model of the bridge.
module tb_apb_master_bridge;

    localparam int NUM_SLV = 4;
    localparam int TO      = 8;

    logic         PCLK;
    logic         PRESETn;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_write;
    logic [31:0]  req_wdata;
    logic [3:0]   req_strb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;
    logic [3:0]   PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // Random activity on every slave; the addressed slave (if any) gets the given values.
    task automatic drive_slaves(input int idx, input logic rdy, input logic err, input logic [31:0] rdval);
        PREADY  = 4'($urandom);
        PSLVERR = 4'($urandom);
        PRDATA  = {$urandom, $urandom, $urandom, $urandom};
        if (idx < NUM_SLV) begin
            PREADY[idx] = rdy;
            if (rdy) PSLVERR[idx] = err;
            PRDATA[idx*32 +: 32] = rdval;
        end
    endtask

    // One full transfer; called at a falling edge with the bridge idle.
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int waits, input logic slverr,
                            input logic [31:0] rdval, input int stall);
        int          idx;
        int          acc_n;
        logic        dec;
        logic        tmo;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_sel;
        logic [3:0]  exp_strb;
        // Reference model: outcome of the whole transfer from address, slave behaviour and limit.
        idx       = int'(addr[15:12]);
        dec       = (idx >= NUM_SLV);
        tmo       = !dec && (waits >= TO);
        exp_err   = dec || tmo || slverr;
        exp_rdata = (dec || tmo || wr) ? 32'h0 : rdval;
        acc_n     = dec ? 0 : (tmo ? TO : waits + 1);
        exp_sel   = dec ? 4'b0 : (4'b1 << idx);
        exp_strb  = wr ? strb : 4'b0;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL idle_req_ready got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata; req_strb = strb;
        drive_slaves(idx, 1'b0, 1'b0, rdval);
        @(posedge PCLK); @(negedge PCLK);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_strb = 4'($urandom); req_write = 1'($urandom);

        if (!dec) begin
            checks++;
            if ({PSEL, PENABLE, rsp_valid} !== {exp_sel, 1'b0, 1'b0}) begin
                errors++; $display("FAIL setup_ctrl psel/penable/rsp_valid got %b/%b/%b want %b/0/0",
                                   PSEL, PENABLE, rsp_valid, exp_sel);
            end
            checks++;
            if ({PADDR, PWRITE, PWDATA, PSTRB} !== {addr, wr, wdata, exp_strb}) begin
                errors++; $display("FAIL setup_bus addr/wr/wdata/strb got %h/%b/%h/%b want %h/%b/%h/%b",
                                   PADDR, PWRITE, PWDATA, PSTRB, addr, wr, wdata, exp_strb);
            end
            drive_slaves(idx, 1'b0, 1'b0, rdval);
            @(posedge PCLK); @(negedge PCLK);
            for (int a = 1; a <= acc_n; a++) begin
                checks++;
                if ({PSEL, PENABLE, rsp_valid} !== {exp_sel, 1'b1, 1'b0}) begin
                    errors++; $display("FAIL access_ctrl cycle %0d psel/penable/rsp_valid got %b/%b/%b want %b/1/0",
                                       a, PSEL, PENABLE, rsp_valid, exp_sel);
                end
                checks++;
                if ({PADDR, PWRITE, PWDATA, PSTRB} !== {addr, wr, wdata, exp_strb}) begin
                    errors++; $display("FAIL access_bus cycle %0d got %h/%b/%h/%b want %h/%b/%h/%b",
                                       a, PADDR, PWRITE, PWDATA, PSTRB, addr, wr, wdata, exp_strb);
                end
                drive_slaves(idx, (a == waits + 1), slverr, rdval);
                @(posedge PCLK); @(negedge PCLK);
            end
        end

        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== {4'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL resp_ctrl psel/penable/rsp_valid got %b/%b/%b want 0000/0/1",
                               PSEL, PENABLE, rsp_valid);
        end
        checks++;
        if ({rsp_err, rsp_rdata} !== {exp_err, exp_rdata}) begin
            errors++; $display("FAIL resp_data err/rdata got %b/%h want %b/%h", rsp_err, rsp_rdata, exp_err, exp_rdata);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge PCLK); @(negedge PCLK);
            checks++;
            if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, exp_err, exp_rdata, 1'b0}) begin
                errors++; $display("FAIL resp_hold valid/err/rdata/req_ready got %b/%b/%h/%b want 1/%b/%h/0",
                                   rsp_valid, rsp_err, rsp_rdata, req_ready, exp_err, exp_rdata);
            end
        end
        rsp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL resp_req_ready got %b want 0", req_ready);
        end
        @(posedge PCLK); @(negedge PCLK);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL resp_clear valid/req_ready got %b/%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        PRESETn = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        req_strb = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = '0; PSLVERR = '0;
        #2 PRESETn = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_1000;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err, req_ready} !== 8'b0) begin
            errors++; $display("FAIL reset_ctrl psel/penable/rsp_valid/rsp_err/req_ready got %b/%b/%b/%b/%b want all 0",
                               PSEL, PENABLE, rsp_valid, rsp_err, req_ready);
        end
        checks++;
        if ({PADDR, PWRITE, PWDATA, PSTRB, rsp_rdata} !== 101'b0) begin
            errors++; $display("FAIL reset_data paddr/pwrite/pwdata/pstrb/rdata got %h/%b/%h/%b/%h want 0",
                               PADDR, PWRITE, PWDATA, PSTRB, rsp_rdata);
        end
        req_valid = 1'b0;
        PRESETn = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        checks++;
        if ({req_ready, rsp_valid, PSEL} !== 6'b100000) begin
            errors++; $display("FAIL reset_release req_ready/rsp_valid/psel got %b/%b/%b want 1/0/0000",
                               req_ready, rsp_valid, PSEL);
        end
    endtask

    task automatic test_write_slv0;
        run_xfer(32'h0000_0004, 1'b1, 32'h0000_A5A5, 4'b0011, 0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_read_waits;
        run_xfer(32'h0000_2008, 1'b0, $urandom, 4'b1111, 3, 1'b0, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_slave_error;
        run_xfer(32'h0000_1000, 1'b0, $urandom, 4'b1111, 1, 1'b1, 32'h0BAD_0BAD, 5);
    endtask

    task automatic test_decode_error;
        run_xfer(32'h0000_5000, 1'b1, 32'h1111_2222, 4'b1111, 0, 1'b0, 32'h0, 2);
    endtask

    task automatic test_timeout;
        run_xfer(32'h0000_3000, 1'b1, $urandom, 4'b1111, TO, 1'b0, 32'h0, 0);
        run_xfer(32'h0000_3004, 1'b0, $urandom, 4'b1111, TO - 1, 1'b0, 32'hCAFE_F00D, 1);
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_addr = 32'h0000_1010; req_write = 1'b0; req_wdata = '0; req_strb = 4'hF;
        drive_slaves(1, 1'b0, 1'b0, 32'h1234_5678);
        @(posedge PCLK); @(negedge PCLK);
        req_valid = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        drive_slaves(1, 1'b0, 1'b0, 32'h1234_5678);
        @(posedge PCLK); @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 5'b0010_1) begin
            errors++; $display("FAIL rst_mid_access psel/penable got %b/%b want 0010/1", PSEL, PENABLE);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 7'b0) begin
            errors++; $display("FAIL rst_mid_async psel/penable/rsp_valid/req_ready got %b/%b/%b/%b want 0",
                               PSEL, PENABLE, rsp_valid, req_ready);
        end
        @(posedge PCLK); @(negedge PCLK);
        PREADY = 4'b1111;
        @(posedge PCLK); @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL rst_mid_no_rsp psel/penable/rsp_valid got %b/%b/%b want 0",
                               PSEL, PENABLE, rsp_valid);
        end
        run_xfer(32'h0000_1010, 1'b0, $urandom, 4'hF, 1, 1'b0, 32'h1234_5678, 0);
    endtask

    task automatic test_random;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            addr = $urandom;
            addr[15:12] = 4'($urandom_range(0, 6));
            run_xfer(addr, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, TO + 1),
                     1'($urandom), $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_write_slv0();
        test_read_waits();
        test_slave_error();
        test_decode_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
